// File: rtl/ext_sram_arbiter_pkg.sv
// Shared definitions for the external SRAM arbiter and its bench.
package ext_sram_arbiter_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT   = 9;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 64;

    // Who owns the data that will appear on mem_dout in the next cycle.
    typedef enum logic [1:0] {
        TagNone  = 2'b00,
        TagCpuRd = 2'b01,
        TagDmaRd = 2'b10
    } owner_tag_e;

    // Active-low byte enables: both high means the access is a read.
    function automatic logic is_read(input logic [1:0] wen);
        return wen == 2'b11;
    endfunction

endpackage

// File: rtl/ext_sram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at LIMIT.
module sat_counter #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned CntWidth = $clog2(LIMIT + 1);

    logic [CntWidth-1:0] count_q;

    // Count up to LIMIT and hold there; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != CntWidth'(LIMIT))) begin
            count_q <= count_q + CntWidth'(1);
        end
    end

    assign at_limit = (count_q == CntWidth'(LIMIT));

endmodule

// File: rtl/ext_sram_arbiter.sv
// Two-master arbiter in front of a single-port SRAM bridge: the CPU always wins,
// the secondary (DMA) master fills idle CPU cycles and gets a starvation flag.
module ext_sram_arbiter
    import ext_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    // CPU RAM port
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_cen,
    input  logic [1:0]            cpu_wen,
    input  logic [15:0]           cpu_din,
    output logic [15:0]           cpu_dout,
    // Secondary master
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [1:0]            dma_wen,
    input  logic [15:0]           dma_din,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [15:0]           dma_dout,
    output logic                  dma_starve,
    // SRAM bridge port
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cen,
    output logic [1:0]            mem_wen,
    output logic [15:0]           mem_din,
    input  logic [15:0]           mem_dout
);

    logic       cpu_acc;
    logic       dma_acc;
    owner_tag_e tag_q;
    owner_tag_e tag_d;
    logic [15:0] cpu_hold_q;
    logic [15:0] dma_hold_q;

    assign cpu_acc = ~cpu_cen;
    // No DMA access may be launched while reset is asserted.
    assign dma_acc = cpu_cen & dma_req & ~rst;
    assign dma_gnt = dma_acc;

    // Combinational steering of the memory port; CPU has the unstalled path.
    always_comb begin
        mem_addr = dma_addr;
        mem_din  = dma_din;
        mem_wen  = 2'b11;
        mem_cen  = 1'b1;
        if (cpu_acc) begin
            mem_addr = cpu_addr;
            mem_din  = cpu_din;
            mem_wen  = cpu_wen;
            mem_cen  = 1'b0;
        end else if (dma_acc) begin
            mem_wen  = dma_wen;
            mem_cen  = 1'b0;
        end
    end

    // Tag the read issued this cycle so its return is routed next cycle.
    always_comb begin
        tag_d = TagNone;
        if (cpu_acc) begin
            if (is_read(cpu_wen)) tag_d = TagCpuRd;
        end else if (dma_acc && is_read(dma_wen)) begin
            tag_d = TagDmaRd;
        end
    end

    // Owner tag and per-master hold registers for returned read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= TagNone;
            cpu_hold_q <= '0;
            dma_hold_q <= '0;
        end else begin
            tag_q <= tag_d;
            if (tag_q == TagCpuRd) cpu_hold_q <= mem_dout;
            if (tag_q == TagDmaRd) dma_hold_q <= mem_dout;
        end
    end

    assign cpu_dout   = (tag_q == TagCpuRd) ? mem_dout : cpu_hold_q;
    assign dma_rvalid = (tag_q == TagDmaRd);
    assign dma_dout   = dma_rvalid ? mem_dout : dma_hold_q;

    // Consecutive cycles of pending-but-refused DMA requests.
    sat_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (dma_req & ~dma_acc),
        .clr     (~dma_req | dma_acc),
        .at_limit(dma_starve)
    );

endmodule

// File: tb/tb_ext_sram_arbiter.sv
// Self-checking bench: behavioural SRAM on the memory port, plus a reference
// model that tracks expected memory contents and read returns per master.
module tb_ext_sram_arbiter;
    import ext_sram_arbiter_pkg::*;

    localparam int unsigned AW    = ADDR_WIDTH_DEFAULT;
    localparam int unsigned LIM   = STARVE_LIMIT_DEFAULT;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_addr;
    logic          cpu_cen;
    logic [1:0]    cpu_wen;
    logic [15:0]   cpu_din;
    logic [15:0]   cpu_dout;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [1:0]    dma_wen;
    logic [15:0]   dma_din;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [15:0]   dma_dout;
    logic          dma_starve;
    logic [AW-1:0] mem_addr;
    logic          mem_cen;
    logic [1:0]    mem_wen;
    logic [15:0]   mem_din;
    logic [15:0]   mem_dout;

    int n_vec  = 0;
    int n_fail = 0;

    ext_sram_arbiter #(
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_cen   (cpu_cen),
        .cpu_wen   (cpu_wen),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .dma_req   (dma_req),
        .dma_addr  (dma_addr),
        .dma_wen   (dma_wen),
        .dma_din   (dma_din),
        .dma_gnt   (dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_dout  (dma_dout),
        .dma_starve(dma_starve),
        .mem_addr  (mem_addr),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int i);
        return 16'((i * 40503) ^ 16'h5A3C);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] wen);
        logic [15:0] r;
        r = old_w;
        if (!wen[0]) r[7:0]  = new_w[7:0];
        if (!wen[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    // Behavioural SRAM bridge: one-cycle read latency, byte-masked writes.
    logic [15:0] sram [DEPTH];
    bit          sram_ready = 1'b0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
            sram_ready <= 1'b1;
        end else if (!mem_cen) begin
            if (mem_wen == 2'b11) mem_dout <= sram[mem_addr];
            else sram[mem_addr] <= merge(sram[mem_addr], mem_din, mem_wen);
        end
    end

    // Reference model state.
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] exp_cpu;
    logic [15:0] exp_dma;
    logic        exp_rvalid;
    int          starve_cnt;

    // Apply one cycle of inputs and move to mid-cycle for sampling.
    task automatic drive(input logic c_cen, input logic [1:0] c_wen, input logic [AW-1:0] c_addr,
                         input logic [15:0] c_din, input logic d_req, input logic [1:0] d_wen,
                         input logic [AW-1:0] d_addr, input logic [15:0] d_din);
        cpu_cen  = c_cen;
        cpu_wen  = c_wen;
        cpu_addr = c_addr;
        cpu_din  = c_din;
        dma_req  = d_req;
        dma_wen  = d_wen;
        dma_addr = d_addr;
        dma_din  = d_din;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        drive(1'b1, 2'b11, '0, '0, 1'b0, 2'b11, '0, '0);
    endtask

    // Advance the reference model by the access issued this cycle, then clock.
    task automatic finish_cycle();
        logic gnt;
        gnt = cpu_cen && dma_req && !rst;
        exp_rvalid = 1'b0;
        if (!cpu_cen) begin
            if (cpu_wen == 2'b11) begin
                if (!rst) exp_cpu = ref_mem[cpu_addr];
            end else begin
                ref_mem[cpu_addr] = merge(ref_mem[cpu_addr], cpu_din, cpu_wen);
            end
        end else if (gnt) begin
            if (dma_wen == 2'b11) begin
                exp_dma    = ref_mem[dma_addr];
                exp_rvalid = 1'b1;
            end else begin
                ref_mem[dma_addr] = merge(ref_mem[dma_addr], dma_din, dma_wen);
            end
        end
        if (rst) begin
            exp_cpu    = '0;
            exp_dma    = '0;
            starve_cnt = 0;
        end else if (dma_req && !gnt) begin
            starve_cnt = (starve_cnt < LIM) ? starve_cnt + 1 : LIM;
        end else begin
            starve_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b11, AW'(7), '0);
            n_vec++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", dma_gnt); end
            n_vec++; if (mem_cen !== 1'b1) begin n_fail++; $display("FAIL rst_mem_cen: got %b want 1", mem_cen); end
            finish_cycle();
        end
        rst = 1'b0;
        drive_idle();
        n_vec++; if (cpu_dout !== 16'h0) begin n_fail++; $display("FAIL rst_cpu_dout: got %h want 0000", cpu_dout); end
        n_vec++; if (dma_dout !== 16'h0) begin n_fail++; $display("FAIL rst_dma_dout: got %h want 0000", dma_dout); end
        n_vec++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", dma_rvalid); end
        n_vec++; if (dma_starve !== 1'b0) begin n_fail++; $display("FAIL rst_starve: got %b want 0", dma_starve); end
        n_vec++; if (mem_wen !== 2'b11) begin n_fail++; $display("FAIL idle_mem_wen: got %b want 11", mem_wen); end
        finish_cycle();
    endtask

    task automatic test_directed_read();
        drive(1'b0, 2'b00, AW'(9'h010), 16'hA5A5, 1'b0, 2'b11, '0, '0);
        finish_cycle();
        drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b00, AW'(9'h020), 16'h1234);
        finish_cycle();
        drive(1'b0, 2'b11, AW'(9'h010), '0, 1'b0, 2'b11, '0, '0);
        n_vec++; if (mem_addr !== AW'(9'h010) || mem_cen !== 1'b0) begin n_fail++; $display("FAIL dir_cpu_issue: got addr %h cen %b want 010 0", mem_addr, mem_cen); end
        finish_cycle();
        drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b11, AW'(9'h020), '0);
        n_vec++; if (cpu_dout !== 16'hA5A5) begin n_fail++; $display("FAIL dir_cpu_ret: got %h want a5a5", cpu_dout); end
        n_vec++; if (dma_gnt !== 1'b1 || mem_addr !== AW'(9'h020)) begin n_fail++; $display("FAIL dir_dma_issue: got gnt %b addr %h want 1 020", dma_gnt, mem_addr); end
        finish_cycle();
        drive_idle();
        n_vec++; if (cpu_dout !== 16'hA5A5) begin n_fail++; $display("FAIL dir_cpu_hold1: got %h want a5a5", cpu_dout); end
        n_vec++; if (dma_rvalid !== 1'b1 || dma_dout !== 16'h1234) begin n_fail++; $display("FAIL dir_dma_ret: got v %b d %h want 1 1234", dma_rvalid, dma_dout); end
        finish_cycle();
        drive_idle();
        n_vec++; if (cpu_dout !== 16'hA5A5) begin n_fail++; $display("FAIL dir_cpu_hold2: got %h want a5a5", cpu_dout); end
        n_vec++; if (dma_rvalid !== 1'b0 || dma_dout !== 16'h1234) begin n_fail++; $display("FAIL dir_dma_hold: got v %b d %h want 0 1234", dma_rvalid, dma_dout); end
        finish_cycle();
    endtask

    task automatic test_dma_write();
        drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b01, AW'(9'h005), 16'hBEEF);
        n_vec++; if (mem_wen !== 2'b01 || mem_din !== 16'hBEEF) begin n_fail++; $display("FAIL dwr_issue: got wen %b din %h want 01 beef", mem_wen, mem_din); end
        n_vec++; if (mem_addr !== AW'(9'h005) || mem_cen !== 1'b0 || dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dwr_port: got addr %h cen %b gnt %b want 005 0 1", mem_addr, mem_cen, dma_gnt); end
        finish_cycle();
        drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b11, AW'(9'h005), '0);
        n_vec++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dwr_no_rvalid: got %b want 0", dma_rvalid); end
        finish_cycle();
        drive_idle();
        n_vec++; if (dma_rvalid !== 1'b1 || dma_dout !== exp_dma) begin n_fail++; $display("FAIL dwr_readback: got v %b d %h want 1 %h", dma_rvalid, dma_dout, exp_dma); end
        finish_cycle();
    endtask

    task automatic test_starve();
        for (int k = 1; k <= int'(LIM); k++) begin
            drive(1'b0, 2'b11, AW'($urandom), '0, 1'b1, 2'b11, AW'($urandom), '0);
            n_vec++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL stv_gnt[%0d]: got %b want 0", k, dma_gnt); end
            n_vec++; if (dma_starve !== (starve_cnt == LIM)) begin n_fail++; $display("FAIL stv_flag[%0d]: got %b want %b", k, dma_starve, starve_cnt == LIM); end
            finish_cycle();
        end
        drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b11, AW'(9'h033), '0);
        n_vec++; if (dma_starve !== 1'b1) begin n_fail++; $display("FAIL stv_at_limit: got %b want 1", dma_starve); end
        n_vec++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL stv_grant: got %b want 1", dma_gnt); end
        finish_cycle();
        drive_idle();
        n_vec++; if (dma_starve !== 1'b0) begin n_fail++; $display("FAIL stv_clear: got %b want 0", dma_starve); end
        n_vec++; if (dma_dout !== exp_dma) begin n_fail++; $display("FAIL stv_data: got %h want %h", dma_dout, exp_dma); end
        finish_cycle();
    endtask

    task automatic test_cpu_priority();
        for (int k = 0; k < 16; k++) begin
            logic [1:0]    w;
            logic [AW-1:0] a;
            logic [15:0]   d;
            w = (k % 2 == 0) ? 2'b11 : 2'($urandom_range(2));
            a = AW'($urandom);
            d = 16'($urandom);
            drive(1'b0, w, a, d, 1'b1, 2'($urandom), AW'($urandom), 16'($urandom));
            n_vec++; if (mem_cen !== 1'b0 || mem_addr !== a || mem_wen !== w) begin n_fail++; $display("FAIL pri_port[%0d]: got cen %b addr %h wen %b want 0 %h %b", k, mem_cen, mem_addr, mem_wen, a, w); end
            n_vec++; if (w != 2'b11 && mem_din !== d) begin n_fail++; $display("FAIL pri_din[%0d]: got %h want %h", k, mem_din, d); end
            n_vec++; if (dma_gnt !== 1'b0) begin n_fail++; $display("FAIL pri_gnt[%0d]: got %b want 0", k, dma_gnt); end
            n_vec++; if (cpu_dout !== exp_cpu) begin n_fail++; $display("FAIL pri_cpu_dout[%0d]: got %h want %h", k, cpu_dout, exp_cpu); end
            finish_cycle();
        end
    endtask

    task automatic test_alternating_random();
        for (int k = 0; k < 256; k++) begin
            logic          wr;
            logic [1:0]    w;
            logic [AW-1:0] a;
            logic [15:0]   d;
            logic          req;
            wr  = ($urandom_range(7) == 0);
            w   = wr ? 2'($urandom_range(2)) : 2'b11;
            a   = AW'($urandom);
            d   = 16'($urandom);
            req = (k % 2 == 1) ? 1'b1 : 1'($urandom_range(1));
            if (k % 2 == 0) drive(1'b0, w, a, d, req, 2'b11, AW'($urandom), '0);
            else            drive(1'b1, 2'b11, '0, '0, 1'b1, w, a, d);
            n_vec++; if (mem_addr !== a || mem_wen !== w) begin n_fail++; $display("FAIL alt_port[%0d]: got addr %h wen %b want %h %b", k, mem_addr, mem_wen, a, w); end
            n_vec++; if (dma_gnt !== (k % 2 == 1)) begin n_fail++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, dma_gnt, k % 2 == 1); end
            n_vec++; if (cpu_dout !== exp_cpu) begin n_fail++; $display("FAIL alt_cpu_dout[%0d]: got %h want %h", k, cpu_dout, exp_cpu); end
            n_vec++; if (dma_rvalid !== exp_rvalid || dma_dout !== exp_dma) begin n_fail++; $display("FAIL alt_dma[%0d]: got v %b d %h want %b %h", k, dma_rvalid, dma_dout, exp_rvalid, exp_dma); end
            n_vec++; if (dma_starve !== (starve_cnt == LIM)) begin n_fail++; $display("FAIL alt_starve[%0d]: got %b want %b", k, dma_starve, starve_cnt == LIM); end
            finish_cycle();
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 2'b11, AW'(9'h0A0), '0, 1'b0, 2'b11, '0, '0);
        finish_cycle();
        drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b11, AW'(9'h0B0), '0);
        n_vec++; if (dma_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_grant: got %b want 1", dma_gnt); end
        n_vec++; if (cpu_dout !== exp_cpu) begin n_fail++; $display("FAIL rmr_cpu_pre: got %h want %h", cpu_dout, exp_cpu); end
        finish_cycle();
        rst = 1'b1;
        drive(1'b1, 2'b11, '0, '0, 1'b1, 2'b11, AW'(9'h0C0), '0);
        n_vec++; if (dma_gnt !== 1'b0 || mem_cen !== 1'b1) begin n_fail++; $display("FAIL rmr_in_rst: got gnt %b cen %b want 0 1", dma_gnt, mem_cen); end
        finish_cycle();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_idle();
            n_vec++; if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_rvalid[%0d]: got %b want 0", k, dma_rvalid); end
            n_vec++; if (cpu_dout !== 16'h0 || dma_dout !== 16'h0) begin n_fail++; $display("FAIL rmr_dout[%0d]: got cpu %h dma %h want 0000 0000", k, cpu_dout, dma_dout); end
            n_vec++; if (dma_starve !== 1'b0) begin n_fail++; $display("FAIL rmr_starve[%0d]: got %b want 0", k, dma_starve); end
            finish_cycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_cen = 1'b1; cpu_wen = 2'b11; cpu_addr = '0; cpu_din = '0;
        dma_req = 1'b0; dma_wen = 2'b11; dma_addr = '0; dma_din = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        exp_cpu = '0; exp_dma = '0; exp_rvalid = 1'b0; starve_cnt = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed_read();
        test_dma_write();
        test_starve();
        test_cpu_priority();
        test_alternating_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_sram_arbiter.md
EXT_SRAM_ARBITER -- requirements
Module: ext_sram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, word-address width on all ports; SHALL match the downstream SRAM bridge.
REQ-002 Parameter STARVE_LIMIT, default 64, count of ungranted DMA request cycles at which dma_starve asserts.
REQ-003 clk  in  1  single clock for all state; rising edge only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_addr / cpu_cen / cpu_wen / cpu_din  in  ADDR_WIDTH/1/2/16  openMSP430 RAM port; cen and wen active-low.
REQ-006 cpu_dout  out  16  read data to core.
REQ-007 dma_req  in  1  secondary-master access request.
REQ-008 dma_addr / dma_wen / dma_din  in  ADDR_WIDTH/2/16  secondary address, active-low byte write enables (2'b11 = read), write data.
REQ-009 dma_gnt  out  1  request accepted this cycle.
REQ-010 dma_rvalid / dma_dout  out  1/16  read data valid strobe and data.
REQ-011 dma_starve  out  1  DMA pending without grant for >= STARVE_LIMIT cycles.
REQ-012 mem_addr / mem_cen / mem_wen / mem_din  out  ADDR_WIDTH/1/2/16  to SRAM bridge RAM port.
REQ-013 mem_dout  in  16  from SRAM bridge; valid the cycle after a read access.

Function
REQ-014 CPU SHALL have absolute priority and never be stalled; when cpu_cen=0, mem_* SHALL equal cpu_* in the same cycle (combinational path).
REQ-015 When cpu_cen=1 and dma_req=1, mem_* SHALL carry dma_* with mem_cen=0, and dma_gnt SHALL be 1 in that cycle.
REQ-016 When neither requests, mem_cen SHALL be 1, mem_wen 2'b11; mem_addr/mem_din don't-care.
REQ-017 dma_gnt SHALL be 0 whenever cpu_cen=0 or rst=1; no DMA access is issued during reset.
REQ-018 Owner tag register, states NONE, CPU_RD, DMA_RD, updated every rising edge from the access issued that cycle: CPU read -> CPU_RD, DMA read -> DMA_RD, any write or idle -> NONE.
REQ-019 While tag=CPU_RD, cpu_dout SHALL equal mem_dout; otherwise cpu_dout SHALL equal cpu_hold register.
REQ-020 cpu_hold SHALL load mem_dout at each rising edge where tag=CPU_RD, so cpu_dout is stable across CPU idle, writes and DMA reads.
REQ-021 dma_rvalid SHALL equal (tag=DMA_RD); dma_dout SHALL equal mem_dout when dma_rvalid=1, else last DMA read data (dma_hold register).
REQ-022 Read latency: one cycle for both masters; back-to-back reads from alternating masters SHALL each return correct data.
REQ-023 Starve counter: increments (saturating at STARVE_LIMIT) each cycle dma_req=1 and dma_gnt=0; clears on dma_gnt=1 or dma_req=0.
REQ-024 dma_starve SHALL be 1 iff counter = STARVE_LIMIT; deasserts the cycle after the clearing grant.
REQ-025 A CPU write and DMA read to the same address SHALL be ordered by issue cycle; no write buffering.

Reset
REQ-026 On rst=1 at a rising edge: tag=NONE, cpu_hold=0, dma_hold=0, starve counter=0; thus cpu_dout=0, dma_dout=0, dma_rvalid=0, dma_starve=0 the following cycle.
REQ-027 Reset mid-read SHALL drop the pending return: no dma_rvalid after reset, cpu_dout reads 0.

Structure
REQ-028 Owner-tag encoding and STARVE_LIMIT default SHALL live in a shared package/header included by both this block and its bench.
REQ-029 The starve counter SHALL be a sub-module sat_counter (width derived from STARVE_LIMIT); all other logic flat.

Verification
REQ-030 CPU read 0x010 (mem returns 0xA5A5), then DMA read 0x020 (0x1234) in the CPU idle cycle -> cpu_dout 0xA5A5 held through both cycles after its return; dma_rvalid one cycle, dma_dout=0x1234.
REQ-031 dma_req held with cpu_cen=0 for 64 cycles -> dma_gnt 0 throughout, dma_starve=1 at cycle 64; cpu_cen=1 -> dma_gnt=1, dma_starve=0 next cycle.
REQ-032 DMA write 0xBEEF to 0x005 with dma_wen=2'b01 -> mem_wen=2'b01, mem_din=0xBEEF, no dma_rvalid.
REQ-033 Simultaneous cpu_cen=0 and dma_req=1 every cycle, CPU alternating read/write -> mem_* always CPU, dma_gnt never 1.
REQ-034 rst asserted the cycle after a DMA read grant -> dma_rvalid stays 0, cpu_dout=0, dma_starve=0.
REQ-035 Alternating CPU/DMA reads on consecutive cycles, 256 random addresses against an SRAM model -> every returned word matches the model for its owner.
